// File: rtl/minbd_pkg.sv
// minbd_pkg: shared flit type, default sizing and head-state encoding for the MinBD side buffer
package minbd_pkg;
  localparam int FLIT_W = 64;
  localparam int DEPTH_DEF = 4;
  localparam int STARVE_LIM_DEF = 8;
  typedef logic [FLIT_W-1:0] flit_t;
  typedef enum logic [1:0] {HS_EMPTY, HS_WAIT, HS_STARVED} head_state_t;
endpackage

// File: rtl/minbd_sync_fifo.sv
// minbd_sync_fifo: DEPTH x WIDTH synchronous FIFO (i_push/i_pop/i_data in; o_data head, zero when empty; o_count, o_full, o_empty)
module minbd_sync_fifo
  import minbd_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]    r_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end
  assign o_count = r_count;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/minbd_side_buffer_reinject.sv
// minbd_side_buffer_reinject: side buffer holding ejected flits, offering the oldest for reinjection and forcing a redirect when it starves
// ports: wr_en/wr_flit push, reinj_ack consumes head; reinj_valid/reinj_flit head, force_redirect, full, count, sticky overflow
module minbd_side_buffer_reinject
  import minbd_pkg::*;
#(
  parameter int WIDTH = FLIT_W,
  parameter int DEPTH = DEPTH_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_flit,
  input  logic                   reinj_ack,
  output logic                   reinj_valid,
  output logic [WIDTH-1:0]       reinj_flit,
  output logic                   force_redirect,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);
  logic          w_empty, w_pop, w_push;
  logic [SW-1:0] r_starve;
  logic          r_overflow;
  head_state_t   w_state;
  assign reinj_valid = ~w_empty;
  assign w_pop       = reinj_ack & reinj_valid;
  // a pop frees a slot in the same edge, so a full buffer still accepts a push alongside it
  assign w_push      = wr_en & (~full | w_pop);
  minbd_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(wr_flit),
    .o_data(reinj_flit),
    .o_count(count),
    .o_full(full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_starve <= (w_empty | w_pop) ? '0 : (r_starve == LIM ? LIM : r_starve + 1'b1);
      if (wr_en & full & ~w_pop) r_overflow <= 1'b1;
    end
  end
  // head state is a pure decode of occupancy and starvation, so no extra state register
  always_comb begin
    w_state = w_empty ? HS_EMPTY : (r_starve == LIM ? HS_STARVED : HS_WAIT);
  end
  assign force_redirect = w_state == HS_STARVED;
  assign overflow       = r_overflow;
endmodule

// File: tb/tb_minbd_side_buffer_reinject.sv
// tb_minbd_side_buffer_reinject: table vectors, corner sequences and random traffic against a queue-based model
module tb_minbd_side_buffer_reinject;
  localparam int W = 64;
  localparam int D = 4;
  localparam int L = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic [W-1:0] wr_flit = '0;
  logic reinj_ack = 1'b0;
  logic reinj_valid, force_redirect, full, overflow;
  logic [W-1:0] reinj_flit;
  logic [2:0] count;
  int n_pass = 0;
  int n_tot = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] popped[$];
  int m_st = 0;
  logic m_ovf = 1'b0;
  typedef struct {
    logic wr; logic [W-1:0] d; logic ack;
    logic ev; logic [W-1:0] ef; int ec; logic efull;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  minbd_side_buffer_reinject #(.WIDTH(W), .DEPTH(D), .STARVE_LIM(L)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_flit(wr_flit), .reinj_ack(reinj_ack),
    .reinj_valid(reinj_valid), .reinj_flit(reinj_flit), .force_redirect(force_redirect),
    .full(full), .count(count), .overflow(overflow)
  );

  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask

  task automatic check_all(input string tag);
    logic v;
    v = mq.size() > 0;
    chk({tag, ".valid"}, W'(reinj_valid), W'(v));
    chk({tag, ".flit"}, reinj_flit, v ? mq[0] : '0);
    chk({tag, ".count"}, W'(count), W'(mq.size()));
    chk({tag, ".full"}, W'(full), W'(mq.size() == D));
    chk({tag, ".force"}, W'(force_redirect), W'(v && m_st == L));
    chk({tag, ".ovf"}, W'(overflow), W'(m_ovf));
  endtask

  task automatic step(input logic w, input logic [W-1:0] d, input logic a, input string tag);
    logic v, p, f, pu;
    wr_en = w; wr_flit = d; reinj_ack = a;
    @(posedge clk);
    v = mq.size() > 0;
    p = a && v;
    f = mq.size() == D;
    pu = w && (!f || p);
    if (w && f && !p) m_ovf = 1'b1;
    m_st = (!v || p) ? 0 : (m_st == L ? L : m_st + 1);
    if (p) begin popped.push_back(mq[0]); void'(mq.pop_front()); end
    if (pu) mq.push_back(d);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input logic w, input logic [W-1:0] d, input logic a);
    reset = 1'b1; wr_en = w; wr_flit = d; reinj_ack = a;
    @(posedge clk);
    mq.delete(); popped.delete(); m_st = 0; m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; reinj_ack = 1'b0;
    check_all("rst");
  endtask

  initial begin
    tbl[0] = '{1'b1, 64'hA1, 1'b0, 1'b1, 64'hA1, 1, 1'b0};
    tbl[1] = '{1'b1, 64'hA2, 1'b0, 1'b1, 64'hA1, 2, 1'b0};
    tbl[2] = '{1'b1, 64'hA3, 1'b0, 1'b1, 64'hA1, 3, 1'b0};
    tbl[3] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'hA2, 2, 1'b0};
    tbl[4] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'hA3, 1, 1'b0};
    tbl[5] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  0, 1'b0};
    tbl[6] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  0, 1'b0};
    tbl[7] = '{1'b1, 64'hB1, 1'b1, 1'b1, 64'hB1, 1, 1'b0};
    @(negedge clk);
    do_reset(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, "idle");
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].ack, "tbl");
      chk("tbl.valid", W'(reinj_valid), W'(tbl[i].ev));
      chk("tbl.flit", reinj_flit, tbl[i].ef);
      chk("tbl.count", W'(count), W'(tbl[i].ec));
      chk("tbl.full", W'(full), W'(tbl[i].efull));
    end
    do_reset(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, W'(64'hC0 + i), 1'b0, "fill");
    step(1'b1, 64'hFF, 1'b0, "drop");
    chk("drop.count", W'(count), 64'd4);
    chk("drop.full", W'(full), 64'd1);
    chk("drop.ovf", W'(overflow), 64'd1);
    step(1'b1, 64'hEE, 1'b1, "pushpop");
    chk("pushpop.count", W'(count), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "drain");
    chk("drain.last", popped[popped.size()-1], 64'hEE);
    chk("drain.n", W'(popped.size()), 64'd5);
    chk("ovf.sticky", W'(overflow), 64'd1);
    foreach (popped[i]) if (popped[i] == 64'hFF) chk("no_ff", popped[i], 64'h0);
    do_reset(1'b0, '0, 1'b0);
    step(1'b1, 64'h5A, 1'b0, "st.push");
    for (int i = 0; i < L - 1; i++) step(1'b0, '0, 1'b0, "st.wait");
    chk("st.before", W'(force_redirect), 64'd0);
    step(1'b0, '0, 1'b0, "st.hit");
    chk("st.force", W'(force_redirect), 64'd1);
    step(1'b0, '0, 1'b0, "st.sat");
    step(1'b1, 64'h5B, 1'b1, "st.ack");
    chk("st.drop", W'(force_redirect), 64'd0);
    chk("st.newhead", reinj_flit, 64'h5B);
    do_reset(1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, W'(64'h100 + i), 1'b0, "wrap.push");
      step(1'b1, W'(64'h200 + i), 1'b1, "wrap.pp");
      step(1'b0, '0, 1'b1, "wrap.pop");
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "wrap.drain");
    chk("wrap.n", W'(popped.size()), 64'd12);
    chk("wrap.first", popped[0], 64'h100);
    chk("wrap.second", popped[1], 64'h200);
    do_reset(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, W'(64'h300 + i), 1'b0, "mid.push");
    for (int i = 0; i < L; i++) step(1'b0, '0, 1'b0, "mid.wait");
    chk("mid.force", W'(force_redirect), 64'd1);
    do_reset(1'b1, 64'hDD, 1'b1);
    chk("mid.valid", W'(reinj_valid), 64'd0);
    chk("mid.flit", reinj_flit, 64'd0);
    chk("mid.count", W'(count), 64'd0);
    step(1'b1, 64'hC1, 1'b0, "mid.first");
    chk("mid.head", reinj_flit, 64'hC1);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0 ? 1 : (i % 50 < 25 ? 0 : 1)), "rnd");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
